mem_wb_pipe: RTL and testbench

//   Parametrised MEM->WB stage register. Replaces the single-entry stage flop.

---
 rtl/mem_wb_pipe_if.sv | 33 +++
 rtl/mem_wb_pipe.sv | 99 +++++++++
 tb/tb_mem_wb_pipe.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_pipe_if.sv
// MEM->WB bus bundle: entry-in handshake, ctrl stall/flush, and the head entry
// presented to the regfile write port(s).
interface mem_wb_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LANES  = 1,
    parameter int DEPTH  = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                      in_valid_in;
    logic                      in_ready_out;
    logic [LANES*DATA_W-1:0]   reg_wdata_in;
    logic [LANES*ADDR_W-1:0]   reg_waddr_in;
    logic [LANES-1:0]          reg_we_in;
    logic                      stall_in;
    logic                      flush_in;
    logic                      out_valid_out;
    logic [LANES*DATA_W-1:0]   reg_wdata_out;
    logic [LANES*ADDR_W-1:0]   reg_waddr_out;
    logic [LANES-1:0]          reg_we_out;
    logic [CNT_W-1:0]          count_out;

    modport master (
        output in_valid_in, reg_wdata_in, reg_waddr_in, reg_we_in, stall_in, flush_in,
        input  in_ready_out, out_valid_out, reg_wdata_out, reg_waddr_out, reg_we_out, count_out
    );

    modport slave (
        input  in_valid_in, reg_wdata_in, reg_waddr_in, reg_we_in, stall_in, flush_in,
        output in_ready_out, out_valid_out, reg_wdata_out, reg_waddr_out, reg_we_out, count_out
    );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM->WB stage buffer: DEPTH-entry circular queue of multi-lane register writes,
// with write qualification at push and combinational head presentation.
module mem_wb_pipe #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int LANES     = 1,
    parameter int DEPTH     = 2,
    parameter int ZERO_DROP = 1
) (
    input  logic          clk_in,
    input  logic          reset_in,
    mem_wb_pipe_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [LANES*DATA_W-1:0] data_q [DEPTH];
    logic [LANES*ADDR_W-1:0] addr_q [DEPTH];
    logic [LANES-1:0]        we_q   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             head_valid;
    logic             in_ready;
    logic             push;
    logic             pop;
    logic [LANES-1:0] we_qual;

    assign head_valid = (count_q != '0);
    assign in_ready   = (count_q < CNT_W'(DEPTH));
    assign push       = bus.in_valid_in & in_ready & ~bus.flush_in;
    assign pop        = head_valid & ~bus.stall_in & ~bus.flush_in;

    // A lane is shadowed when any higher lane writes the same register in this entry.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [ADDR_W-1:0] lane_addr;
            logic              shadowed;

            assign lane_addr = bus.reg_waddr_in[gi*ADDR_W +: ADDR_W];

            always_comb begin
                shadowed = 1'b0;
                for (int j = gi + 1; j < LANES; j++) begin
                    if (bus.reg_we_in[j] && (bus.reg_waddr_in[j*ADDR_W +: ADDR_W] == lane_addr))
                        shadowed = 1'b1;
                end
            end

            assign we_qual[gi] = bus.reg_we_in[gi] & ~shadowed
                               & ~((ZERO_DROP != 0) && (lane_addr == '0));
        end
    endgenerate

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (bus.flush_in) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)
                count_d = count_q + CNT_W'(1);
            else if (!push && pop)
                count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int k = 0; k < DEPTH; k++) we_q[k] <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push) begin
                data_q[wr_ptr_q] <= bus.reg_wdata_in;
                addr_q[wr_ptr_q] <= bus.reg_waddr_in;
                we_q[wr_ptr_q]   <= we_qual;
            end
        end
    end

    // Empty buffer presents all-zero outputs so stale storage never leaks out.
    assign bus.in_ready_out  = in_ready;
    assign bus.out_valid_out = head_valid;
    assign bus.reg_we_out    = head_valid ? we_q[rd_ptr_q]   : '0;
    assign bus.reg_wdata_out = head_valid ? data_q[rd_ptr_q] : '0;
    assign bus.reg_waddr_out = head_valid ? addr_q[rd_ptr_q] : '0;
    assign bus.count_out     = count_q;
endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: two instances (DEPTH 2 and 4, two lanes) share one stimulus
// stream; a queue model checks both every cycle, directed literals pin key points.
module tb_mem_wb_pipe;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int LN = 2;

    typedef struct {
        logic [LN*DW-1:0] d;
        logic [LN*AW-1:0] a;
        logic [LN-1:0]    w;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, stall, flush;
    logic [LN*DW-1:0] wdata;
    logic [LN*AW-1:0] waddr;
    logic [LN-1:0]    we;

    int n_chk  = 0;
    int n_fail = 0;
    bit model_on = 1'b0;
    bit track_b  = 1'b0;
    int b_pops   = 0;

    ent_t qa[$];
    ent_t qb[$];

    always #5 clk = ~clk;

    mem_wb_pipe_if #(.DATA_W(DW), .ADDR_W(AW), .LANES(LN), .DEPTH(2)) bus_a ();
    mem_wb_pipe_if #(.DATA_W(DW), .ADDR_W(AW), .LANES(LN), .DEPTH(4)) bus_b ();

    assign bus_a.in_valid_in  = in_valid;
    assign bus_a.reg_wdata_in = wdata;
    assign bus_a.reg_waddr_in = waddr;
    assign bus_a.reg_we_in    = we;
    assign bus_a.stall_in     = stall;
    assign bus_a.flush_in     = flush;
    assign bus_b.in_valid_in  = in_valid;
    assign bus_b.reg_wdata_in = wdata;
    assign bus_b.reg_waddr_in = waddr;
    assign bus_b.reg_we_in    = we;
    assign bus_b.stall_in     = stall;
    assign bus_b.flush_in     = flush;

    mem_wb_pipe #(.DATA_W(DW), .ADDR_W(AW), .LANES(LN), .DEPTH(2), .ZERO_DROP(1)) u_dut_a (
        .clk_in(clk), .reset_in(rst_n), .bus(bus_a));
    mem_wb_pipe #(.DATA_W(DW), .ADDR_W(AW), .LANES(LN), .DEPTH(4), .ZERO_DROP(1)) u_dut_b (
        .clk_in(clk), .reset_in(rst_n), .bus(bus_b));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Highest lane wins: walk lanes top-down, a lane loses if its register is already claimed.
    function automatic ent_t qualify(logic [LN*DW-1:0] d, logic [LN*AW-1:0] a, logic [LN-1:0] w);
        ent_t e;
        bit claimed [32];
        e.d = d;
        e.a = a;
        e.w = '0;
        for (int i = 0; i < 32; i++) claimed[i] = 1'b0;
        for (int l = LN - 1; l >= 0; l--) begin
            int r;
            r = int'(a[l*AW +: AW]);
            if (w[l]) begin
                e.w[l] = (r != 0) && !claimed[r];
                claimed[r] = 1'b1;
            end
        end
        return e;
    endfunction

    always @(posedge clk) begin : model
        automatic bit pop_a, push_a, pop_b, push_b;
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            model_on <= 1'b1;
        end else if (flush) begin
            qa.delete();
            qb.delete();
        end else begin
            pop_a  = (qa.size() != 0) && !stall;
            push_a = in_valid && (qa.size() < 2);
            pop_b  = (qb.size() != 0) && !stall;
            push_b = in_valid && (qb.size() < 4);
            if (pop_a)  void'(qa.pop_front());
            if (push_a) qa.push_back(qualify(wdata, waddr, we));
            if (pop_b)  void'(qb.pop_front());
            if (push_b) qb.push_back(qualify(wdata, waddr, we));
        end
    end

    always @(negedge clk) begin : compare
        ent_t ea, eb;
        if (model_on) begin
            ea = '{d: '0, a: '0, w: '0};
            eb = '{d: '0, a: '0, w: '0};
            if (qa.size() != 0) ea = qa[0];
            if (qb.size() != 0) eb = qb[0];
            chk("A.ready", bus_a.in_ready_out,  qa.size() < 2);
            chk("A.valid", bus_a.out_valid_out, qa.size() != 0);
            chk("A.count", bus_a.count_out,     qa.size());
            chk("A.we",    bus_a.reg_we_out,    ea.w);
            chk("A.data",  bus_a.reg_wdata_out, ea.d);
            chk("A.addr",  bus_a.reg_waddr_out, ea.a);
            chk("B.ready", bus_b.in_ready_out,  qb.size() < 4);
            chk("B.valid", bus_b.out_valid_out, qb.size() != 0);
            chk("B.count", bus_b.count_out,     qb.size());
            chk("B.we",    bus_b.reg_we_out,    eb.w);
            chk("B.data",  bus_b.reg_wdata_out, eb.d);
            chk("B.addr",  bus_b.reg_waddr_out, eb.a);
            if (track_b && rst_n && bus_b.out_valid_out && !stall && !flush) begin
                chk("B.order", bus_b.reg_wdata_out[DW-1:0], 64'h100 + 64'(b_pops));
                b_pops++;
            end
        end
    end

    task automatic set_in(input logic v, input logic [LN*DW-1:0] d, input logic [LN*AW-1:0] a,
                          input logic [LN-1:0] w, input logic st, input logic fl);
        in_valid = v; wdata = d; waddr = a; we = w; stall = st; flush = fl;
        if (v) $display("tx: push d=%h a=%h we=%b stall=%b flush=%b", d, a, w, st, fl);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int k, cyc;
        logic acc;
        logic [AW-1:0] ad;
        rst_n = 1'b0;
        set_in(1'b1, {32'h0, 32'h1234}, {5'd0, 5'd1}, 2'b01, 1'b0, 1'b0);

        // 1. reset held for two cycles with in_valid high
        tick; tick;
        rst_n = 1'b1;
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b0);
        chk("rst.valid", bus_a.out_valid_out, 0);
        chk("rst.we",    bus_a.reg_we_out, 0);
        chk("rst.data",  bus_a.reg_wdata_out, 0);
        chk("rst.addr",  bus_a.reg_waddr_out, 0);
        chk("rst.count", bus_a.count_out, 0);
        chk("rst.ready", bus_a.in_ready_out, 1);

        // 2. pass-through
        set_in(1'b1, {32'h0, 32'hDEADBEEF}, {5'd0, 5'd5}, 2'b01, 1'b0, 1'b0);
        tick;
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b0);
        chk("pt.valid", bus_a.out_valid_out, 1);
        chk("pt.data",  bus_a.reg_wdata_out[31:0], 32'hDEADBEEF);
        chk("pt.addr",  bus_a.reg_waddr_out[4:0], 5);
        chk("pt.we",    bus_a.reg_we_out, 2'b01);
        chk("pt.count", bus_a.count_out, 1);
        tick;
        chk("pt.drain", bus_a.count_out, 0);

        // 3. fill under stall, third entry refused, then drain in order
        set_in(1'b1, {32'h11, 32'hA1}, {5'd1, 5'd2}, 2'b11, 1'b1, 1'b0);
        tick;
        set_in(1'b1, {32'h12, 32'hA2}, {5'd3, 5'd4}, 2'b11, 1'b1, 1'b0);
        tick;
        set_in(1'b1, {32'h13, 32'hA3}, {5'd5, 5'd6}, 2'b11, 1'b1, 1'b0);
        chk("full.ready", bus_a.in_ready_out, 0);
        chk("full.count", bus_a.count_out, 2);
        chk("full.head",  bus_a.reg_wdata_out[31:0], 32'hA1);
        chk("full.we",    bus_a.reg_we_out, 2'b11);
        tick;
        chk("hold.count", bus_a.count_out, 2);
        chk("hold.head",  bus_a.reg_wdata_out[31:0], 32'hA1);
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b0);
        tick;
        chk("order.head",  bus_a.reg_wdata_out[31:0], 32'hA2);
        chk("order.count", bus_a.count_out, 1);
        tick;
        chk("order.empty", bus_a.count_out, 0);
        tick;

        // 4. flush with a simultaneous push
        set_in(1'b1, {32'h21, 32'hB1}, {5'd7, 5'd8}, 2'b01, 1'b1, 1'b0);
        tick;
        set_in(1'b1, {32'h22, 32'hB2}, {5'd7, 5'd9}, 2'b01, 1'b1, 1'b0);
        tick;
        chk("fl.pre", bus_a.count_out, 2);
        set_in(1'b1, {32'h0, 32'hBAD}, {5'd0, 5'd10}, 2'b01, 1'b0, 1'b1);
        tick;
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b0);
        chk("fl.count", bus_a.count_out, 0);
        chk("fl.we",    bus_a.reg_we_out, 0);
        chk("fl.valid", bus_a.out_valid_out, 0);
        chk("fl.ready", bus_a.in_ready_out, 1);
        chk("fl.bcnt",  bus_b.count_out, 0);
        tick;
        chk("fl.gone", bus_a.out_valid_out, 0);

        // 5. lane qualification
        set_in(1'b1, {32'h44, 32'h33}, {5'd3, 5'd3}, 2'b11, 1'b0, 1'b0);
        tick;
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b0);
        chk("q.conflict", bus_a.reg_we_out, 2'b10);
        chk("q.cdata",    bus_a.reg_wdata_out, {32'h44, 32'h33});
        tick;
        set_in(1'b1, {32'h66, 32'h55}, {5'd7, 5'd0}, 2'b11, 1'b0, 1'b0);
        tick;
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b0);
        chk("q.zero",  bus_a.reg_we_out, 2'b10);
        chk("q.zaddr", bus_a.reg_waddr_out, {5'd7, 5'd0});
        chk("q.zdata", bus_a.reg_wdata_out, {32'h66, 32'h55});
        tick; tick;
        chk("q.bempty", bus_b.count_out, 0);

        // 6. ten tagged entries through DEPTH 4 with random stalls
        track_b = 1'b1;
        k = 0;
        cyc = 0;
        while (k < 10 && cyc < 200) begin
            ad = AW'(k + 1);
            set_in(1'b1, {32'h0, 32'h100 + 32'(k)}, {5'd0, ad}, 2'b01,
                   1'($urandom_range(0, 1)), 1'b0);
            acc = bus_b.in_ready_out;
            tick;
            if (acc) k++;
            cyc++;
        end
        chk("wrap.pushed", k, 10);
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b0);
        cyc = 0;
        while (bus_b.count_out != 0 && cyc < 20) begin
            tick;
            cyc++;
        end
        tick;
        chk("wrap.popped", b_pops, 10);
        chk("wrap.empty",  bus_b.count_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
